// File: rtl/apb_slave_mem_if.sv
// APB bus signals between the bridge and one slave memory instance.
interface apb_slave_mem_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB slave word memory with a programmable number of wait states.
// Address, direction and write data are latched in SETUP so that bus
// changes during ACCESS cannot alter the transfer being committed.
module apb_slave_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic           pclk,
  input  logic           Reset_n,
  apb_slave_mem_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic              pready_q;
  logic [DATA_W-1:0] prdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              in_range;
  logic [IDX_W-1:0]  idx;

  // Out-of-range addresses are rejected before the truncated index is used,
  // so high addresses never alias onto implemented words.
  assign in_range = (32'(addr_q) < 32'(DEPTH));
  assign idx      = addr_q[IDX_W-1:0];

  assign bus.pready = pready_q;
  assign bus.prdata = prdata_q;

  // Transfer FSM, wait counter, memory array and registered outputs.
  always_ff @(posedge pclk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          pready_q <= 1'b0;
          if (bus.psel && !bus.penable) begin
            state   <= SETUP;
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
          end
        end

        SETUP: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (bus.penable) begin
            state    <= ACCESS;
            wait_cnt <= 4'(WAIT_STATES);
          end else begin
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
          end
        end

        ACCESS: begin
          if (!bus.psel) begin
            state <= IDLE;
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            if (write_q) begin
              if (in_range) begin
                mem[idx] <= wdata_q;
              end
              prdata_q <= '0;
            end else begin
              prdata_q <= in_range ? mem[idx] : '0;
            end
            pready_q <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          pready_q <= 1'b0;
          if (bus.psel && !bus.penable) begin
            state   <= SETUP;
            addr_q  <= bus.paddr;
            write_q <= bus.pwrite;
            wdata_q <= bus.pwdata;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances share the bridge
// fan-out (one psel each) with different wait states and depths.
module tb_apb_slave_mem;

  logic        pclk    = 1'b0;
  logic        Reset_n = 1'b0;
  logic [2:0]  psel_v  = '0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [4:0]  paddr   = '0;
  logic [31:0] pwdata  = '0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int          dut;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  logic [2:0]  pready_v;
  logic [31:0] prdata_v [3];

  apb_slave_mem_if #(.ADDR_W(5), .DATA_W(32)) if_a ();
  apb_slave_mem_if #(.ADDR_W(5), .DATA_W(32)) if_b ();
  apb_slave_mem_if #(.ADDR_W(5), .DATA_W(32)) if_c ();

  assign if_a.psel    = psel_v[0];
  assign if_a.penable = penable;
  assign if_a.pwrite  = pwrite;
  assign if_a.paddr   = paddr;
  assign if_a.pwdata  = pwdata;

  assign if_b.psel    = psel_v[1];
  assign if_b.penable = penable;
  assign if_b.pwrite  = pwrite;
  assign if_b.paddr   = paddr;
  assign if_b.pwdata  = pwdata;

  assign if_c.psel    = psel_v[2];
  assign if_c.penable = penable;
  assign if_c.pwrite  = pwrite;
  assign if_c.paddr   = paddr;
  assign if_c.pwdata  = pwdata;

  assign pready_v    = {if_c.pready, if_b.pready, if_a.pready};
  assign prdata_v[0] = if_a.prdata;
  assign prdata_v[1] = if_b.prdata;
  assign prdata_v[2] = if_c.prdata;

  apb_slave_mem #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT_STATES(2)) u_a (
    .pclk(pclk), .Reset_n(Reset_n), .bus(if_a.slave));
  apb_slave_mem #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .WAIT_STATES(0)) u_b (
    .pclk(pclk), .Reset_n(Reset_n), .bus(if_b.slave));
  apb_slave_mem #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .WAIT_STATES(1)) u_c (
    .pclk(pclk), .Reset_n(Reset_n), .bus(if_c.slave));

  // Free-running clock.
  always #5 pclk = ~pclk;

  // Edge counter used to timestamp expected pready cycles.
  always @(posedge pclk) cycle <= cycle + 1;

  function automatic int ws_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 0 : 1);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle(input int n);
    psel_v  = '0;
    penable = 1'b0;
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // Full transfer: setup now, enable next cycle, then wait for pready.
  // Called #1 after a rising edge; leaves the bus selected so a following
  // call forms a back-to-back transfer.
  task automatic apply_stimulus(input int d, input logic wr, input logic [4:0] a,
                                input logic [31:0] wd, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    psel_v    = '0;
    psel_v[d] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = wd;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    e.dut   = d;
    e.data  = wr ? 32'h0 : exp_rd;
    e.cyc   = cycle + ws_of(d) + 2;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(posedge pclk);
      #1;
      n++;
    end while (!pready_v[d] && n < 40);
    penable = 1'b0;
    if (!pready_v[d]) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout dut=%0d addr=%0d: pready not seen, want within 40 cycles",
               d, a);
    end
  endtask

  // Monitor: every pready must match the oldest expected response.
  always @(negedge pclk) begin
    for (int d = 0; d < 3; d++) begin
      if (pready_v[d] === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pready dut=%0d: got 1, want 0", d);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("resp_dut", d, mon_e.dut);
          check_output("resp_prdata", prdata_v[d], mon_e.data);
          check_output("resp_cycle", cycle, mon_e.cyc);
        end
      end
    end
  end

  // Directed test sequence.
  initial begin
    repeat (3) @(posedge pclk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_output("reset_pready", {31'b0, pready_v[d]}, 32'h0);
      check_output("reset_prdata", prdata_v[d], 32'h0);
    end
    Reset_n = 1'b1;
    @(posedge pclk);
    #1;

    // Enable without a setup phase is ignored; no write happens.
    psel_v  = 3'b001;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 5'd9;
    pwdata  = 32'h0000_0099;
    repeat (3) begin
      @(posedge pclk);
      #1;
    end
    bus_idle(1);
    apply_stimulus(0, 1'b0, 5'd9, 32'h0, 32'h0);
    bus_idle(1);

    // Two wait states: write then read back.
    apply_stimulus(0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h0);
    bus_idle(1);
    apply_stimulus(0, 1'b0, 5'd3, 32'h0, 32'hDEAD_BEEF);
    bus_idle(3);
    check_output("prdata_hold", prdata_v[0], 32'hDEAD_BEEF);

    // Abort during the ACCESS wait: psel dropped while the counter is 1.
    psel_v  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 5'd5;
    pwdata  = 32'h0000_AAAA;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    repeat (2) begin
      @(posedge pclk);
      #1;
    end
    bus_idle(2);
    check_output("abort_prdata", prdata_v[0], 32'hDEAD_BEEF);
    apply_stimulus(0, 1'b0, 5'd5, 32'h0, 32'h0);
    bus_idle(1);
    apply_stimulus(0, 1'b0, 5'd3, 32'h0, 32'hDEAD_BEEF);
    bus_idle(1);

    // Reset while the counter is 1 on a pending write.
    psel_v  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 5'd7;
    pwdata  = 32'h0000_1234;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    repeat (2) begin
      @(posedge pclk);
      #1;
    end
    Reset_n = 1'b0;
    @(posedge pclk);
    #1;
    check_output("midreset_pready", {31'b0, pready_v[0]}, 32'h0);
    check_output("midreset_prdata", prdata_v[0], 32'h0);
    Reset_n = 1'b1;
    bus_idle(1);
    apply_stimulus(0, 1'b0, 5'd7, 32'h0, 32'h0);
    bus_idle(1);
    apply_stimulus(0, 1'b0, 5'd3, 32'h0, 32'h0);
    bus_idle(1);

    // Zero wait states, back-to-back transfers.
    apply_stimulus(1, 1'b1, 5'd0, 32'h11, 32'h0);
    apply_stimulus(1, 1'b1, 5'd31, 32'h22, 32'h0);
    apply_stimulus(1, 1'b0, 5'd0, 32'h0, 32'h11);
    apply_stimulus(1, 1'b0, 5'd31, 32'h0, 32'h22);
    bus_idle(2);

    // Depth 16: address 20 is out of range and must not alias onto 4.
    apply_stimulus(2, 1'b1, 5'd4, 32'h44, 32'h0);
    bus_idle(1);
    apply_stimulus(2, 1'b1, 5'd20, 32'h55, 32'h0);
    bus_idle(1);
    apply_stimulus(2, 1'b0, 5'd20, 32'h0, 32'h0);
    bus_idle(1);
    apply_stimulus(2, 1'b0, 5'd4, 32'h0, 32'h44);
    bus_idle(3);

    check_output("scoreboard_drain", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
